// File: rtl/ca_pkg.sv
// Shared types and constants for the elementary cellular-automaton engine.
// Holds the control FSM state encoding and the rule width.
package ca_pkg;

  localparam int RULE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ca_state_t;

endpackage

// File: rtl/ca_rule_lut.sv
// One-cell rule lookup: next cell value = rule[{left, centre, right}].
// Purely combinational, zero latency, no flow control.
module ca_rule_lut
  import ca_pkg::*;
(
  input  logic [RULE_W-1:0] rule,
  input  logic [2:0]        nbhd,
  output logic              cell_nxt
);

  assign cell_nxt = rule[nbhd];

endmodule

// File: rtl/ca_engine.sv
// Elementary CA engine: load/step/free-run with generation counter, stop and stability detect.
// One generation per cycle; load_ready low while free-running, done pulses the cycle after RUN exits.
module ca_engine
  import ca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RULE_W-1:0] rule,
  input  logic              wrap,
  input  logic              left,
  input  logic              right,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_state,
  input  logic              run,
  input  logic              step,
  input  logic              stop,
  input  logic [CNT_W-1:0]  gen_limit,
  output logic [WIDTH-1:0]  out,
  output logic [CNT_W-1:0]  gen_count,
  output logic              busy,
  output logic              done,
  output logic              stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ca_state_t         state, state_nxt;
  logic [RULE_W-1:0] rule_q;
  logic              wrap_q;
  logic [CNT_W-1:0]  remaining;
  logic              do_load, do_sample, do_gen, do_arm, done_nxt;
  logic [RULE_W-1:0] rule_use;
  logic              wrap_use;
  logic [WIDTH-1:0]  gen_nxt;
  logic              gen_stable;

  // A step computes with the rule arriving with it; a free run uses the latched copy.
  assign rule_use   = (state == IDLE) ? rule : rule_q;
  assign wrap_use   = (state == IDLE) ? wrap : wrap_q;
  assign gen_stable = (gen_nxt == out);
  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic nb_l, nb_r;
    if (i == 0) begin : g_left_edge
      assign nb_l = wrap_use ? out[WIDTH-1] : left;
    end else begin : g_left_inner
      assign nb_l = out[i-1];
    end
    if (i == WIDTH - 1) begin : g_right_edge
      assign nb_r = wrap_use ? out[0] : right;
    end else begin : g_right_inner
      assign nb_r = out[i+1];
    end
    ca_rule_lut u_lut (
      .rule     (rule_use),
      .nbhd     ({nb_l, out[i], nb_r}),
      .cell_nxt (gen_nxt[i])
    );
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_gen    = 1'b0;
    do_arm    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          do_load = 1'b1;
        end else if (run) begin
          do_sample = 1'b1;
          if (gen_limit == '0) begin
            done_nxt = 1'b1;
          end else begin
            do_arm    = 1'b1;
            state_nxt = RUN;
          end
        end else if (step) begin
          do_sample = 1'b1;
          do_gen    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          do_gen = 1'b1;
          if (remaining == CNT_ONE || gen_stable) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      done      <= 1'b0;
      rule_q    <= '0;
      wrap_q    <= 1'b0;
      remaining <= '0;
    end else begin
      done <= done_nxt;
      if (do_sample) begin
        rule_q <= rule;
        wrap_q <= wrap;
      end
      if (do_arm) begin
        remaining <= gen_limit;
      end else if (do_gen && state == RUN) begin
        remaining <= remaining - CNT_ONE;
      end
      if (do_load) begin
        out       <= load_state;
        gen_count <= '0;
        stable    <= 1'b0;
      end else if (do_gen) begin
        out    <= gen_nxt;
        stable <= gen_stable;
        if (gen_count != CNT_MAX) gen_count <= gen_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ca_engine.sv
// Randomized scoreboard bench for ca_engine: a generation-level reference model queues
// expected states; a monitor compares them whenever out/gen_count change or done pulses.
module tb_ca_engine;

  localparam int W  = 32;
  localparam int CW = 8;
  localparam int GC_MAX = 255;

  logic          clk, rst_n;
  logic [7:0]    rule;
  logic          wrap, left, right;
  logic          load_valid, load_ready;
  logic [W-1:0]  load_state;
  logic          run, step, stop;
  logic [CW-1:0] gen_limit;
  logic [W-1:0]  out;
  logic [CW-1:0] gen_count;
  logic          busy, done, stable;

  ca_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rule       (rule),
    .wrap       (wrap),
    .left       (left),
    .right      (right),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_state (load_state),
    .run        (run),
    .step       (step),
    .stop       (stop),
    .gen_limit  (gen_limit),
    .out        (out),
    .gen_count  (gen_count),
    .busy       (busy),
    .done       (done),
    .stable     (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    int           gc;
    logic         st;
  } exp_t;

  exp_t         gen_q[$];
  exp_t         done_q[$];
  logic [W-1:0] m_out;
  int           m_gc;
  logic         m_stable;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Elementary CA generation from the rule table, neighbours formed as shifted copies.
  function automatic logic [W-1:0] next_gen(input logic [W-1:0] s, input logic [7:0] r,
                                            input logic w, input logic lb, input logic rb);
    logic [W-1:0] ln, rn, n;
    ln = {s[W-2:0], (w ? s[W-1] : lb)};
    rn = {(w ? s[0] : rb), s[W-1:1]};
    for (int i = 0; i < W; i++) n[i] = r[{ln[i], s[i], rn[i]}];
    return n;
  endfunction

  function automatic int sat_inc(input int g);
    return (g < GC_MAX) ? g + 1 : GC_MAX;
  endfunction

  function automatic void apply(input logic [W-1:0] o, input int gc, input logic st);
    if (o != m_out || gc != m_gc) gen_q.push_back('{o, gc, st});
    m_out    = o;
    m_gc     = gc;
    m_stable = st;
  endfunction

  initial begin : monitor
    logic [W-1:0] po;
    int           pgc;
    exp_t         e;
    po  = '0;
    pgc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (out != po || int'(gen_count) != pgc) begin
          if (gen_q.size() == 0) begin
            chk("gen_unexpected", {24'd0, gen_count}, 32'hFFFF_FFFF);
          end else begin
            e = gen_q.pop_front();
            chk("gen_out", out, e.o);
            chk("gen_count", {24'd0, gen_count}, e.gc);
            chk("gen_stable", {31'd0, stable}, {31'd0, e.st});
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("done_unexpected", {31'd0, done}, 32'd0);
          end else begin
            e = done_q.pop_front();
            chk("done_out", out, e.o);
            chk("done_count", {24'd0, gen_count}, e.gc);
            chk("done_stable", {31'd0, stable}, {31'd0, e.st});
            chk("done_busy", {31'd0, busy}, 32'd0);
          end
        end
      end
      po  = out;
      pgc = int'(gen_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v, input bit collide);
    apply(v, 0, 1'b0);
    load_valid = 1'b1;
    load_state = v;
    run        = collide;
    step       = collide;
    gen_limit  = 8'd3;
    tick();
    load_valid = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
  endtask

  task automatic do_step();
    logic [W-1:0] n;
    n = next_gen(m_out, rule, wrap, left, right);
    apply(n, sat_inc(m_gc), n == m_out);
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_run(input int limit, input int stop_at, input bit hold_load,
                        input logic [W-1:0] lv, input bit noise);
    logic [W-1:0] n;
    logic         st;
    int           rem, g, c;
    g   = 0;
    rem = limit;
    if (limit > 0) begin
      forever begin
        if (g == stop_at - 1) break;
        n  = next_gen(m_out, rule, wrap, left, right);
        st = (n == m_out);
        apply(n, sat_inc(m_gc), st);
        g++;
        rem--;
        if (rem == 0 || st) break;
      end
    end
    done_q.push_back('{m_out, m_gc, m_stable});
    if (hold_load) apply(lv, 0, 1'b0);
    gen_limit = CW'(limit);
    run       = 1'b1;
    step      = noise;
    tick();
    run  = 1'b0;
    step = 1'b0;
    if (hold_load) begin
      load_valid = 1'b1;
      load_state = lv;
    end
    c = 1;
    while (!done) begin
      if (c > limit + 20) begin
        chk("run_timeout", 32'(c), 32'(limit));
        break;
      end
      chk("run_busy", {31'd0, busy}, 32'd1);
      if (hold_load) chk("run_load_ready", {31'd0, load_ready}, 32'd0);
      stop = (c == stop_at);
      if (noise) begin
        rule = 8'($urandom);
        wrap = 1'($urandom);
        run  = 1'($urandom);
        step = 1'($urandom);
      end
      tick();
      c++;
    end
    stop = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    if (hold_load) begin
      tick();
      load_valid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0; rule = '0; wrap = 1'b0; left = 1'b0; right = 1'b0;
    load_valid = 1'b0; load_state = '0; run = 1'b0; step = 1'b0; stop = 1'b0;
    gen_limit = '0;
    m_out = '0; m_gc = 0; m_stable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_count", {24'd0, gen_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stable", {31'd0, stable}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // Rule 90 single seed, one generation.
    rule = 8'd90; wrap = 1'b0; left = 1'b0; right = 1'b0;
    do_load(32'h0001_0000, 1'b0);
    do_run(1, 0, 1'b0, '0, 1'b0);
    chk("r90_out", out, 32'h0002_8000);
    chk("r90_count", {24'd0, gen_count}, 32'd1);
    chk("r90_done", {31'd0, done}, 32'd1);

    // Identity rule stabilises after one generation.
    rule = 8'd204;
    do_load(32'hA5A5_A5A5, 1'b0);
    do_run(100, 0, 1'b0, '0, 1'b0);
    chk("ident_stable", {31'd0, stable}, 32'd1);
    chk("ident_count", {24'd0, gen_count}, 32'd1);

    // Ring shift returns after WIDTH steps; fixed boundary drains the seed.
    rule = 8'd2; wrap = 1'b1;
    do_load(32'h0000_0001, 1'b0);
    for (int i = 0; i < W; i++) do_step();
    chk("ring_out", out, 32'h0000_0001);
    chk("ring_count", {24'd0, gen_count}, 32'd32);
    wrap = 1'b0;
    do_load(32'h0000_0001, 1'b0);
    do_step();
    chk("fixed_out", out, 32'd0);

    // Stop four cycles after run.
    rule = 8'd30; wrap = 1'b0;
    do_load(32'h0001_0000, 1'b0);
    do_run(10, 4, 1'b0, '0, 1'b0);
    chk("stop_count", {24'd0, gen_count}, 32'd3);
    tick();
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_done_pulse", {31'd0, done}, 32'd0);

    // Load held during RUN is taken only after exit.
    do_load(32'h0001_0000, 1'b0);
    do_run(5, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("held_load_out", out, 32'hDEAD_BEEF);
    chk("held_load_count", {24'd0, gen_count}, 32'd0);

    // Generation counter saturates.
    rule = 8'd2; wrap = 1'b1;
    do_load(32'h0000_0001, 1'b0);
    do_run(200, 0, 1'b0, '0, 1'b0);
    do_run(100, 0, 1'b0, '0, 1'b0);
    chk("sat_count", {24'd0, gen_count}, 32'd255);
    do_step();
    chk("sat_step_count", {24'd0, gen_count}, 32'd255);

    // Asynchronous reset in the middle of a run.
    mon_en = 1'b0;
    load_valid = 1'b1; load_state = 32'h0001_0000; tick(); load_valid = 1'b0;
    rule = 8'd30; wrap = 1'b0; gen_limit = 8'd50;
    run = 1'b1; tick(); run = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_count", {24'd0, gen_count}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_count", {24'd0, gen_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    m_out = '0; m_gc = 0; m_stable = 1'b0;
    gen_q.delete();
    done_q.delete();
    mon_en = 1'b1;
    tick();

    // Randomized mix of loads, steps and runs with colliding requests and mid-run noise.
    for (int it = 0; it < 80; it++) begin
      int op;
      op    = $urandom_range(0, 9);
      rule  = 8'($urandom);
      wrap  = 1'($urandom);
      left  = 1'($urandom);
      right = 1'($urandom);
      if (op < 2) begin
        do_load(W'($urandom), 1'($urandom));
      end else if (op < 5) begin
        do_step();
      end else begin
        do_run($urandom_range(0, 12),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0,
               ($urandom_range(0, 5) == 0), W'($urandom), 1'b1);
      end
    end

    repeat (3) tick();
    chk("gen_q_drained", 32'(gen_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
